// File: rtl/sn_pkg.sv
// Shared definitions for the stochastic-number blocks: default width, decoder
// FSM states and the bipolar conversion used by both the RTL and reference models.
package sn_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } sn_state_e;

  // Bipolar value of a window of 2^l_log2 bits holding `count` ones: 2*count - 2^L.
  function automatic int sn_bipolar(input int count, input int l_log2);
    return (count <<< 1) - (1 << l_log2);
  endfunction

endpackage

// File: rtl/sn_window_decoder_if.sv
// Stream-in / result-out bundle for the stochastic window decoder.
// Handshake: a result transfers on a rising clk edge where out_valid & out_ready are both 1;
// out_count/out_bipolar stay stable while out_valid=1 until that edge. sn_bit is
// only meaningful on cycles with sn_valid=1 (no back-pressure on the bit stream).
interface sn_window_decoder_if #(
  parameter int CNT_W = sn_pkg::CNT_W_DEF
);
  import sn_pkg::*;

  logic             en;
  logic [3:0]       win_log2;
  logic             sn_bit;
  logic             sn_valid;
  logic [CNT_W:0]   out_count;
  logic [CNT_W+1:0] out_bipolar;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;
  logic             clr_ovr;
  logic             busy;
  sn_state_e        state_dbg;

  modport master (
    output en, win_log2, sn_bit, sn_valid, out_ready, clr_ovr,
    input  out_count, out_bipolar, out_valid, overrun, busy, state_dbg
  );

  modport slave (
    input  en, win_log2, sn_bit, sn_valid, out_ready, clr_ovr,
    output out_count, out_bipolar, out_valid, overrun, busy, state_dbg
  );

endinterface

// File: rtl/sn_out_reg.sv
// One-entry valid/ready result register with a sticky overrun flag for results
// that arrive while the entry is still occupied.
module sn_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W:0]   load_count,
  input  logic [W+1:0] load_bipolar,
  input  logic         out_ready,
  input  logic         clr_ovr,
  output logic [W:0]   out_count,
  output logic [W+1:0] out_bipolar,
  output logic         out_valid,
  output logic         overrun
);

  logic consume;
  logic accept;
  logic drop;

  assign consume = out_valid & out_ready;
  // A result may replace one that is leaving on this same edge.
  assign accept  = load & (~out_valid | out_ready);
  assign drop    = load & ~accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count   <= '0;
      out_bipolar <= '0;
      out_valid   <= 1'b0;
    end else if (accept) begin
      out_count   <= load_count;
      out_bipolar <= load_bipolar;
      out_valid   <= 1'b1;
    end else if (consume) begin
      out_valid   <= 1'b0;
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_ovr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/sn_window_decoder.sv
// Counts ones in back-to-back windows of 2^L qualified stochastic bits and hands
// each window's unipolar count and bipolar value to a one-entry output register.
module sn_window_decoder
  import sn_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input logic                clk,
  input logic                rst_n,
  sn_window_decoder_if.slave bus
);

  sn_state_e        state;
  sn_state_e        state_nxt;
  logic [3:0]       l_eff;
  logic [3:0]       l_start;
  logic [CNT_W:0]   ones_cnt;
  logic [CNT_W:0]   bit_cnt;
  logic [CNT_W:0]   last_idx;
  logic [CNT_W:0]   final_count;
  logic [CNT_W+1:0] final_bipolar;
  logic             start;
  logic             qual;
  logic             done;

  assign l_start     = (bus.win_log2 > 4'(CNT_W)) ? 4'(CNT_W) : bus.win_log2;
  assign last_idx    = ((CNT_W+1)'(1) << l_eff) - (CNT_W+1)'(1);
  assign start       = (state == IDLE) & bus.en;
  // Abort (en low) takes precedence over any bit presented in the same cycle.
  assign qual        = (state == ACCUM) & bus.en & bus.sn_valid;
  assign done        = qual & (bit_cnt == last_idx);
  assign final_count = ones_cnt + (CNT_W+1)'(bus.sn_bit);
  assign final_bipolar = (CNT_W+2)'(sn_bipolar(int'(final_count), int'(l_eff)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.en)  state_nxt = ACCUM;
      ACCUM:   if (!bus.en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Completion re-latches L and clears the counters so the next window has no gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_eff    <= '0;
      ones_cnt <= '0;
      bit_cnt  <= '0;
    end else if (start || done) begin
      l_eff    <= l_start;
      ones_cnt <= '0;
      bit_cnt  <= '0;
    end else if ((state == ACCUM) && !bus.en) begin
      ones_cnt <= '0;
      bit_cnt  <= '0;
    end else if (qual) begin
      ones_cnt <= final_count;
      bit_cnt  <= bit_cnt + (CNT_W+1)'(1);
    end
  end

  sn_out_reg #(
    .W (CNT_W)
  ) u_out_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (done),
    .load_count   (final_count),
    .load_bipolar (final_bipolar),
    .out_ready    (bus.out_ready),
    .clr_ovr      (bus.clr_ovr),
    .out_count    (bus.out_count),
    .out_bipolar  (bus.out_bipolar),
    .out_valid    (bus.out_valid),
    .overrun      (bus.overrun)
  );

  assign bus.busy      = (state == ACCUM);
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_sn_window_decoder.sv
// Bench for sn_window_decoder: constant-table windows, directed corner sequences
// and a randomized run, all checked each cycle against a queue-based window model.
module tb_sn_window_decoder;

  localparam int CNT_W = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  sn_window_decoder_if #(.CNT_W(CNT_W)) bus ();

  sn_window_decoder #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit m_active;
  int m_l;
  int m_bits[$];
  bit m_valid;
  int m_count;
  int m_bip;
  bit m_ovr;

  function automatic int clamp_l(input int wl);
    return (wl > CNT_W) ? CNT_W : wl;
  endfunction

  task automatic model_reset();
    m_active = 0;
    m_l      = 0;
    m_bits.delete();
    m_valid  = 0;
    m_count  = 0;
    m_bip    = 0;
    m_ovr    = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_apply();
    bit complete;
    bit drop;
    int cnt;
    complete = 0;
    drop     = 0;
    cnt      = 0;
    if (m_active) begin
      if (!bus.en) begin
        m_active = 0;
        m_bits.delete();
      end else if (bus.sn_valid) begin
        m_bits.push_back(int'(bus.sn_bit));
        if (m_bits.size() == (1 << m_l)) begin
          complete = 1;
          foreach (m_bits[k]) cnt += m_bits[k];
        end
      end
    end else if (bus.en) begin
      m_active = 1;
      m_l      = clamp_l(int'(bus.win_log2));
      m_bits.delete();
    end
    if (complete) begin
      if (!m_valid || bus.out_ready) begin
        m_valid = 1;
        m_count = cnt;
        m_bip   = 2 * cnt - (1 << m_l);
      end else begin
        drop  = 1;
        m_ovr = 1;
      end
      m_l = clamp_l(int'(bus.win_log2));
      m_bits.delete();
    end else if (m_valid && bus.out_ready) begin
      m_valid = 0;
    end
    if (bus.clr_ovr && !drop) m_ovr = 0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("busy",        int'(bus.busy),               int'(m_active));
    check("out_valid",   int'(bus.out_valid),          int'(m_valid));
    check("overrun",     int'(bus.overrun),            int'(m_ovr));
    check("out_count",   int'(bus.out_count),          m_count);
    check("out_bipolar", int'($signed(bus.out_bipolar)), m_bip);
  endtask

  // ---------------- driver ----------------
  task automatic cycle();
    model_apply();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic start_window(input int l, input bit ready);
    bus.en        = 1'b0;
    bus.sn_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.clr_ovr   = 1'b0;
    cycle();
    bus.win_log2  = 4'(l);
    bus.en        = 1'b1;
    bus.out_ready = ready;
    cycle();
  endtask

  function automatic bit pat_bit(input int pat, input int idx);
    case (pat)
      0:       return 1'b0;
      1:       return 1'b1;
      default: return (idx % 2 == 0);
    endcase
  endfunction

  typedef struct {
    int l;
    int pat;        // 0 zeros, 1 ones, 2 alternating starting with 1
    int exp_count;
    int exp_bip;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int hits[$];
    int seen;
    int bits6[6];

    tbl[0] = '{3,  1, 8,   8};
    tbl[1] = '{4,  2, 8,   0};
    tbl[2] = '{4,  0, 0,   -16};
    tbl[3] = '{0,  1, 1,   1};
    tbl[4] = '{0,  0, 0,   -1};
    tbl[5] = '{2,  2, 2,   0};
    tbl[6] = '{1,  2, 1,   0};
    tbl[7] = '{8,  1, 256, 256};
    tbl[8] = '{9,  1, 256, 256};
    tbl[9] = '{15, 0, 0,   -256};

    n_checks = 0;
    n_fail   = 0;
    rst_n         = 1'b0;
    bus.en        = 1'b0;
    bus.win_log2  = 4'd0;
    bus.sn_bit    = 1'b0;
    bus.sn_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.clr_ovr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_count",   int'(bus.out_count), 0);
    check("rst_bipolar", int'($signed(bus.out_bipolar)), 0);
    check("rst_valid",   int'(bus.out_valid), 0);
    check("rst_overrun", int'(bus.overrun), 0);
    check("rst_busy",    int'(bus.busy), 0);
    rst_n = 1'b1;
    model_reset();

    // Table: one window per entry, constant expectations.
    for (int i = 0; i < 10; i++) begin
      start_window(tbl[i].l, 1'b1);
      for (int j = 0; j < (1 << clamp_l(tbl[i].l)); j++) begin
        bus.sn_valid = 1'b1;
        bus.sn_bit   = pat_bit(tbl[i].pat, j);
        cycle();
      end
      bus.sn_valid = 1'b0;
      check("tbl_valid",   int'(bus.out_valid), 1);
      check("tbl_count",   int'(bus.out_count), tbl[i].exp_count);
      check("tbl_bipolar", int'($signed(bus.out_bipolar)), tbl[i].exp_bip);
      check("tbl_overrun", int'(bus.overrun), 0);
    end

    // sn_valid toggling at L=2: a result every 8 cycles.
    start_window(2, 1'b1);
    for (int c = 0; c < 24; c++) begin
      bus.sn_valid = (c % 2 == 0);
      bus.sn_bit   = 1'b1;
      cycle();
      if (bus.out_valid) begin
        hits.push_back(c);
        check("tog_count", int'(bus.out_count), 4);
      end
    end
    check("tog_results", hits.size(), 3);
    foreach (hits[k]) check("tog_spacing", hits[k], 6 + 8 * k);

    // Output held for three windows at L=1 with out_ready low.
    bits6 = '{1, 0, 1, 1, 0, 0};
    start_window(1, 1'b0);
    for (int j = 0; j < 6; j++) begin
      bus.sn_valid = 1'b1;
      bus.sn_bit   = bits6[j][0];
      cycle();
      if (j == 1) begin
        check("hold1_valid",   int'(bus.out_valid), 1);
        check("hold1_count",   int'(bus.out_count), 1);
        check("hold1_overrun", int'(bus.overrun), 0);
      end
      if (j >= 3) begin
        check("hold_count",   int'(bus.out_count), 1);
        check("hold_bipolar", int'($signed(bus.out_bipolar)), 0);
      end
      if (j == 3 || j == 5) check("hold_overrun", int'(bus.overrun), 1);
    end
    bus.sn_valid = 1'b0;
    bus.clr_ovr  = 1'b1;
    cycle();
    check("clr_overrun", int'(bus.overrun), 0);
    bus.clr_ovr   = 1'b0;
    bus.out_ready = 1'b1;
    cycle();
    check("drain_valid", int'(bus.out_valid), 0);

    // Final bit coincides with consumption of the previous result.
    start_window(1, 1'b0);
    bus.sn_valid = 1'b1;
    bus.sn_bit   = 1'b1;
    cycle();
    cycle();
    check("co_first_count", int'(bus.out_count), 2);
    bus.sn_bit = 1'b0;
    cycle();
    bus.out_ready = 1'b1;
    cycle();
    check("co_valid",   int'(bus.out_valid), 1);
    check("co_count",   int'(bus.out_count), 0);
    check("co_bipolar", int'($signed(bus.out_bipolar)), -2);
    check("co_overrun", int'(bus.overrun), 0);

    // Abort after 5 of 8 bits, then a clamped 256-bit window.
    start_window(3, 1'b1);
    for (int j = 0; j < 5; j++) begin
      bus.sn_valid = 1'b1;
      bus.sn_bit   = 1'b1;
      cycle();
    end
    bus.en = 1'b0;
    cycle();
    check("abort_busy",  int'(bus.busy), 0);
    check("abort_valid", int'(bus.out_valid), 0);
    bus.win_log2 = 4'd9;
    bus.en       = 1'b1;
    bus.sn_valid = 1'b0;
    cycle();
    seen = 0;
    for (int j = 0; j < 255; j++) begin
      bus.sn_valid = 1'b1;
      bus.sn_bit   = 1'b1;
      cycle();
      if (bus.out_valid) seen++;
    end
    check("long_early", seen, 0);
    cycle();
    check("long_valid",   int'(bus.out_valid), 1);
    check("long_count",   int'(bus.out_count), 256);
    check("long_bipolar", int'($signed(bus.out_bipolar)), 256);

    // Asynchronous reset in the middle of a window.
    for (int j = 0; j < 3; j++) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", int'(bus.out_valid), 0);
    check("arst_count", int'(bus.out_count), 0);
    check("arst_busy",  int'(bus.busy), 0);
    model_reset();
    #1;
    rst_n = 1'b1;

    // Randomized run against the model.
    for (int c = 0; c < 4000; c++) begin
      bus.en        = ($urandom_range(0, 39) != 0);
      bus.win_log2  = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15))
                                                   : 4'($urandom_range(0, 4));
      bus.sn_bit    = 1'($urandom_range(0, 1));
      bus.sn_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.clr_ovr   = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
